// File: rtl/polyvec_decompress_seq.sv
// Decompresses the Kyber compressed-u polyvec: 10-bit packed bytes from the ciphertext
// buffer are expanded to 12-bit coefficients and written to the polyvec memory.
module polyvec_decompress_seq #(
  parameter int KYBER_K    = 2,
  parameter int KYBER_N    = 256,
  parameter int KYBER_Q    = 3329,
  parameter int POLY_BYTES = 320,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 10,
  parameter int COEF_W     = 12
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic [7:0]                   rd_data,
  output logic                         wr_en,
  output logic [$clog2(KYBER_K)+7:0]   wr_addr,
  output logic [COEF_W-1:0]            wr_data,
  input  logic                         wr_ready
);

  localparam int P_W    = (KYBER_K > 1) ? $clog2(KYBER_K) : 1;
  localparam int WA_W   = $clog2(KYBER_K) + 8;
  localparam int G_LAST = KYBER_N / 4 - 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_EMIT, S_DONE} state_t;

  state_t            state, state_nx;
  logic [P_W-1:0]    p;
  logic [5:0]        g;
  logic [2:0]        b;
  logic [1:0]        j;
  logic [4:0][7:0]   grp;
  logic              pend;
  logic [2:0]        pend_idx;
  logic              last_group, last_poly;
  logic [9:0]        t_sel;
  logic [23:0]       prod;
  logic [31:0]       rd_addr_full;

  assign last_group = (g == 6'(G_LAST));
  assign last_poly  = (p == P_W'(KYBER_K - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: if (b == 3'd4) state_nx = S_CAPT;
      S_CAPT:  state_nx = S_EMIT;
      S_EMIT:  if (wr_ready && j == 2'd3)
                 state_nx = (last_group && last_poly) ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Read data lands one cycle after its strobe; pend/pend_idx track which byte it is.
  // Clearing pend on abort drops a read that is still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p        <= '0;
      g        <= '0;
      b        <= '0;
      j        <= '0;
      grp      <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
    end else begin
      pend     <= (state == S_FETCH) && !abort;
      pend_idx <= b;
      if (pend && !abort) grp[pend_idx] <= rd_data;
      if (abort) begin
        p <= '0;
        g <= '0;
        b <= '0;
        j <= '0;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            p <= '0;
            g <= '0;
            b <= '0;
            j <= '0;
          end
          S_FETCH: b <= (b == 3'd4) ? 3'd0 : b + 3'd1;
          S_CAPT:  j <= '0;
          S_EMIT: if (wr_ready) begin
            if (j == 2'd3) begin
              j <= '0;
              if (last_group) begin
                g <= '0;
                if (!last_poly) p <= p + 1'b1;
              end else begin
                g <= g + 6'd1;
              end
            end else begin
              j <= j + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    unique case (j)
      2'd0:    t_sel = {grp[1][1:0], grp[0]};
      2'd1:    t_sel = {grp[2][3:0], grp[1][7:2]};
      2'd2:    t_sel = {grp[3][5:0], grp[2][7:4]};
      default: t_sel = {grp[4], grp[3][7:6]};
    endcase
    prod = 24'(t_sel) * 24'(KYBER_Q) + 24'd512;
  end

  always_comb begin
    rd_addr_full = 32'(BASE_ADDR) + 32'(p) * 32'(POLY_BYTES) + 32'(g) * 32'd5 + 32'(b);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    rd_en   = (state == S_FETCH);
    wr_en   = (state == S_EMIT);
    rd_addr = rd_en ? ADDR_W'(rd_addr_full) : '0;
    wr_addr = wr_en ? WA_W'({p, g, j}) : '0;
    wr_data = wr_en ? COEF_W'(prod >> 10) : '0;
  end

endmodule

// File: tb/tb_polyvec_decompress_seq.sv
// Directed bench for polyvec_decompress_seq: byte-buffer model, write logger, timing checks.
module tb_polyvec_decompress_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       wr_ready = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic       busy, done, rd_en, wr_en;
  logic [9:0] rd_addr;
  logic [8:0] wr_addr;
  logic [11:0] wr_data;

  polyvec_decompress_seq #(.KYBER_K(2), .BASE_ADDR(0), .ADDR_W(10), .COEF_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= rd_en ? mem[rd_addr] : 8'hA5;
  end

  // Logger (negedge, away from the active edge)
  logic log_clr = 1'b0;
  int rd_cnt, first_rd, first_wr, first_busy, acc_cnt, last_acc, done_cnt, done_cyc;
  int hold_err, overlap_err, done_busy_err;
  int first_rd_addr;
  int rd_seen [0:1023];
  logic [8:0]  acc_addr [0:599];
  logic [11:0] acc_data [0:599];
  logic        hold_pend;
  logic [8:0]  hold_addr;
  logic [11:0] hold_data;

  always @(negedge clk) begin
    if (log_clr) begin
      rd_cnt = 0; first_rd = -1; first_wr = -1; first_busy = -1; acc_cnt = 0; last_acc = -1;
      done_cnt = 0; done_cyc = -1; hold_err = 0; overlap_err = 0; done_busy_err = 0;
      first_rd_addr = -1; hold_pend = 1'b0;
      for (int i = 0; i < 1024; i++) rd_seen[i] = 0;
    end else begin
      if (busy && first_busy < 0) first_busy = cyc;
      if (rd_en) begin
        if (first_rd < 0) begin first_rd = cyc; first_rd_addr = int'(rd_addr); end
        rd_seen[rd_addr] = rd_seen[rd_addr] + 1;
        rd_cnt++;
      end
      if (wr_en && first_wr < 0) first_wr = cyc;
      if (rd_en && wr_en) overlap_err++;
      if (hold_pend && (!wr_en || wr_addr != hold_addr || wr_data != hold_data)) hold_err++;
      hold_pend = wr_en && !wr_ready;
      hold_addr = wr_addr;
      hold_data = wr_data;
      if (wr_en && wr_ready) begin
        if (acc_cnt < 600) begin acc_addr[acc_cnt] = wr_addr; acc_data[acc_cnt] = wr_data; end
        acc_cnt++;
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!busy) done_busy_err++;
      end
    end
  end

  // Reference: the 5 group bytes form a little-endian 40-bit word, coefficient j is bits 10j+9:10j
  function automatic int exp_coef(input int idx);
    int base, j, t;
    logic [39:0] w;
    base = (idx / 256) * 320 + ((idx % 256) / 4) * 5;
    j = idx % 4;
    w = {mem[base+4], mem[base+3], mem[base+2], mem[base+1], mem[base]};
    t = int'((w >> (10 * j)) & 40'h3FF);
    return (t * 3329 + 512) / 1024;
  endfunction

  task automatic clear_log;
    @(posedge clk); #1 log_clr = 1'b1;
    @(posedge clk); #1 log_clr = 1'b0;
  endtask

  task automatic start_run;
    @(posedge clk); #1 start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit bp);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1 wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    wr_ready = 1'b1;
    total++;
    if (done_cnt == 0) begin bad++; $display("FAIL %s_timeout got no done within %0d cycles", name, budget); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
    total++; if (rd_en !== 1'b0)  begin bad++; $display("FAIL rst_rd_en got=%0b exp=0", rd_en); end
    total++; if (wr_en !== 1'b0)  begin bad++; $display("FAIL rst_wr_en got=%0b exp=0", wr_en); end
    total++; if (rd_addr !== 10'd0) begin bad++; $display("FAIL rst_rd_addr got=%0d exp=0", rd_addr); end
    total++; if (wr_addr !== 9'd0)  begin bad++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
    total++; if (wr_data !== 12'd0) begin bad++; $display("FAIL rst_wr_data got=%0d exp=0", wr_data); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_log();
  endtask

  task automatic test_single_group;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h08; mem[3] = 8'h00; mem[4] = 8'hFF;
    mem[5] = 8'hFF; mem[6] = 8'hFC; mem[7] = 8'hF0; mem[8] = 8'h00; mem[9] = 8'h01;
    mem[321] = 8'h04;
    clear_log();
    start_run();
    wait_done("single", 2000, 1'b0);
    total++; if (acc_data[0] !== 12'd3)    begin bad++; $display("FAIL sg_c0 got=%0d exp=3", acc_data[0]); end
    total++; if (acc_data[1] !== 12'd1665) begin bad++; $display("FAIL sg_c1 got=%0d exp=1665", acc_data[1]); end
    total++; if (acc_data[2] !== 12'd0)    begin bad++; $display("FAIL sg_c2 got=%0d exp=0", acc_data[2]); end
    total++; if (acc_data[3] !== 12'd3316) begin bad++; $display("FAIL sg_c3 got=%0d exp=3316", acc_data[3]); end
    total++; if (acc_addr[3] !== 9'd3)     begin bad++; $display("FAIL sg_a3 got=%0d exp=3", acc_addr[3]); end
    total++; if (acc_data[4] !== 12'd829)  begin bad++; $display("FAIL g1_c0 got=%0d exp=829", acc_data[4]); end
    total++; if (acc_data[5] !== 12'd205)  begin bad++; $display("FAIL g1_c1 got=%0d exp=205", acc_data[5]); end
    total++; if (acc_data[6] !== 12'd49)   begin bad++; $display("FAIL g1_c2 got=%0d exp=49", acc_data[6]); end
    total++; if (acc_data[7] !== 12'd13)   begin bad++; $display("FAIL g1_c3 got=%0d exp=13", acc_data[7]); end
    total++; if (acc_addr[257] !== 9'd257 || acc_data[257] !== 12'd3)
      begin bad++; $display("FAIL p1_c1 got addr=%0d data=%0d exp addr=257 data=3", acc_addr[257], acc_data[257]); end
    total++; if (first_busy - start_cyc != 1) begin bad++; $display("FAIL t_busy got=%0d exp=1", first_busy - start_cyc); end
    total++; if (first_rd - start_cyc != 1)   begin bad++; $display("FAIL t_first_rd got=%0d exp=1", first_rd - start_cyc); end
    total++; if (first_wr - start_cyc != 7)   begin bad++; $display("FAIL t_first_wr got=%0d exp=7", first_wr - start_cyc); end
    total++; if (last_acc - start_cyc != 1280) begin bad++; $display("FAIL t_last_wr got=%0d exp=1280", last_acc - start_cyc); end
    total++; if (done_cyc - start_cyc != 1281) begin bad++; $display("FAIL t_done got=%0d exp=1281", done_cyc - start_cyc); end
  endtask

  task automatic test_all_ff;
    int ea, ed, er;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    clear_log();
    start_run();
    wait_done("all_ff", 2000, 1'b0);
    ea = 0; ed = 0; er = 0;
    for (int i = 0; i < 512; i++) begin
      if (acc_addr[i] !== 9'(i)) ea++;
      if (acc_data[i] !== 12'd3326) ed++;
    end
    for (int i = 0; i < 1024; i++) if (rd_seen[i] != ((i < 640) ? 1 : 0)) er++;
    total++; if (acc_cnt != 512) begin bad++; $display("FAIL ff_writes got=%0d exp=512", acc_cnt); end
    total++; if (ea != 0) begin bad++; $display("FAIL ff_addr_seq got=%0d bad exp=0", ea); end
    total++; if (ed != 0) begin bad++; $display("FAIL ff_data got=%0d bad exp=0", ed); end
    total++; if (er != 0 || rd_cnt != 640) begin bad++; $display("FAIL ff_reads got=%0d bad cnt=%0d exp=0 cnt=640", er, rd_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ff_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (done_cyc - start_cyc != 1281) begin bad++; $display("FAIL ff_done_t got=%0d exp=1281", done_cyc - start_cyc); end
    total++; if (done_busy_err != 0) begin bad++; $display("FAIL ff_done_busy got=%0d exp=0", done_busy_err); end
  endtask

  task automatic test_backpressure;
    int ea, ed;
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
    clear_log();
    start_run();
    wait_done("bp", 6000, 1'b1);
    ea = 0; ed = 0;
    for (int i = 0; i < 512; i++) begin
      if (acc_addr[i] !== 9'(i)) ea++;
      if (int'(acc_data[i]) != exp_coef(i)) ed++;
    end
    total++; if (acc_cnt != 512) begin bad++; $display("FAIL bp_writes got=%0d exp=512", acc_cnt); end
    total++; if (ea != 0) begin bad++; $display("FAIL bp_addr_seq got=%0d bad exp=0", ea); end
    total++; if (ed != 0) begin bad++; $display("FAIL bp_data got=%0d bad exp=0", ed); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    total++; if (overlap_err != 0) begin bad++; $display("FAIL bp_rd_in_emit got=%0d exp=0", overlap_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (done_cyc != last_acc + 1) begin bad++; $display("FAIL bp_done_t got=%0d exp=%0d", done_cyc, last_acc + 1); end
  endtask

  task automatic test_abort;
    int n, ed;
    clear_log();
    start_run();
    n = 0;
    while (!(rd_en && rd_addr == 10'd50) && n < 2000) begin @(negedge clk); n++; end
    total++; if (n >= 2000) begin bad++; $display("FAIL ab_reach_g10 got timeout exp=rd_addr 50"); end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    total++; if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0)
      begin bad++; $display("FAIL ab_idle got busy=%0b rd_en=%0b wr_en=%0b exp=0", busy, rd_en, wr_en); end
    total++; if (acc_cnt != 40) begin bad++; $display("FAIL ab_writes got=%0d exp=40", acc_cnt); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (done_cnt != 0) begin bad++; $display("FAIL ab_no_done got=%0d exp=0", done_cnt); end
    clear_log();
    start_run();
    wait_done("ab_restart", 2000, 1'b0);
    ed = 0;
    for (int i = 0; i < 512; i++) if (int'(acc_data[i]) != exp_coef(i) || acc_addr[i] !== 9'(i)) ed++;
    total++; if (first_rd_addr != 0) begin bad++; $display("FAIL ab_restart_addr got=%0d exp=0", first_rd_addr); end
    total++; if (acc_cnt != 512 || ed != 0) begin bad++; $display("FAIL ab_restart_data got cnt=%0d bad=%0d exp cnt=512 bad=0", acc_cnt, ed); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ab_restart_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_ignored_start;
    clear_log();
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_abort_start got busy=%0b exp=0", busy); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (rd_cnt != 0) begin bad++; $display("FAIL ign_no_reads got=%0d exp=0", rd_cnt); end
    start_run();
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ign", 2000, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (acc_cnt != 512) begin bad++; $display("FAIL ign_writes got=%0d exp=512", acc_cnt); end
    total++; if (done_cyc - start_cyc != 1281) begin bad++; $display("FAIL ign_done_t got=%0d exp=1281", done_cyc - start_cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_after got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_midrun;
    clear_log();
    start_run();
    while (cyc - start_cyc < 500) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0)
      begin bad++; $display("FAIL mr_ctrl got busy=%0b done=%0b rd_en=%0b wr_en=%0b exp=0", busy, done, rd_en, wr_en); end
    total++; if (rd_addr !== 10'd0 || wr_addr !== 9'd0 || wr_data !== 12'd0)
      begin bad++; $display("FAIL mr_data got rd_addr=%0d wr_addr=%0d wr_data=%0d exp=0", rd_addr, wr_addr, wr_data); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (done_cnt != 0) begin bad++; $display("FAIL mr_no_done got=%0d exp=0", done_cnt); end
    clear_log();
    start_run();
    wait_done("mr_restart", 2000, 1'b0);
    total++; if (done_cyc - start_cyc != 1281) begin bad++; $display("FAIL mr_done_t got=%0d exp=1281", done_cyc - start_cyc); end
    total++; if (done_cnt != 1 || acc_cnt != 512) begin bad++; $display("FAIL mr_run got done=%0d writes=%0d exp=1,512", done_cnt, acc_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_all_ff();
    test_backpressure();
    test_abort();
    test_ignored_start();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
